// File: rtl/busqueda_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default parameter values.
package busqueda_pkg;

  localparam int          ANCHO_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int          INCREMENTO_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } estado_t;

endpackage

// File: rtl/reg_if_id.sv
// IF/ID output register: captures {instruction, PC} on load, drops valid on
// clear and holds its contents otherwise.
module reg_if_id #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cargar,
  input  logic             i_limpiar,
  input  logic [ANCHO-1:0] i_data,
  input  logic [ANCHO-1:0] i_pc,
  output logic             o_valid,
  output logic [ANCHO-1:0] o_data,
  output logic [ANCHO-1:0] o_pc
);

  logic             r_valid;
  logic [ANCHO-1:0] r_data;
  logic [ANCHO-1:0] r_pc;

  // Load wins over clear; the controller never asserts both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_cargar) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_limpiar) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: drives the PC register input, fetches over req/ack
// and hands {instruction, PC} to decode. Macro UNIDAD_BUSQUEDA_STATS_EN adds counters.
module unidad_busqueda
  import busqueda_pkg::*;
#(
  parameter int               ANCHO      = ANCHO_DEF,
  parameter logic [ANCHO-1:0] RESET_PC   = ANCHO'(RESET_PC_DEF),
  parameter int               INCREMENTO = INCREMENTO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] pc_actual,
  output logic [ANCHO-1:0] pc_siguiente,
  input  logic             salto_valido,
  input  logic [ANCHO-1:0] salto_destino,
  output logic             mem_req,
  output logic [ANCHO-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [ANCHO-1:0] mem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ANCHO-1:0] inst_data,
  output logic [ANCHO-1:0] inst_pc
`ifdef UNIDAD_BUSQUEDA_STATS_EN
  ,
  output logic [ANCHO-1:0] stat_espera,
  output logic [ANCHO-1:0] stat_descartes
`endif
);

  estado_t          r_estado, w_estado_sig;
  logic             r_descartar, w_descartar_sig;
  logic [ANCHO-1:0] r_mem_addr;
  logic             w_cargar, w_limpiar, w_descarta_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= IDLE;
      r_descartar <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_estado    <= w_estado_sig;
      r_descartar <= w_descartar_sig;
      if (r_estado == IDLE) r_mem_addr <= pc_actual;
    end
  end

  always_comb begin
    w_estado_sig    = r_estado;
    w_descartar_sig = r_descartar;
    w_cargar        = 1'b0;
    w_limpiar       = 1'b0;
    w_descarta_ack  = 1'b0;
    pc_siguiente    = pc_actual;
    case (r_estado)
      IDLE: if (!salto_valido) w_estado_sig = FETCH;
      FETCH: begin
        if (mem_ack) begin
          // A redirect arriving with the ack makes this word stale too.
          if (r_descartar || salto_valido) begin
            w_descarta_ack  = 1'b1;
            w_descartar_sig = 1'b0;
            w_estado_sig    = IDLE;
          end else begin
            w_cargar     = 1'b1;
            pc_siguiente = pc_actual + ANCHO'(INCREMENTO);
            w_estado_sig = OUT;
          end
        end else if (salto_valido) begin
          w_descartar_sig = 1'b1;
        end
      end
      OUT: begin
        if (inst_ready || salto_valido) begin
          w_limpiar    = 1'b1;
          w_estado_sig = IDLE;
        end
      end
      default: w_estado_sig = IDLE;
    endcase
    if (salto_valido) pc_siguiente = salto_destino;
    // The PC register has no reset of its own; force it from here.
    if (!rst_n) pc_siguiente = RESET_PC;
  end

  assign mem_req  = (r_estado == FETCH);
  assign mem_addr = r_mem_addr;

  reg_if_id #(.ANCHO(ANCHO)) u_reg_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cargar  (w_cargar),
    .i_limpiar (w_limpiar),
    .i_data    (mem_rdata),
    .i_pc      (r_mem_addr),
    .o_valid   (inst_valid),
    .o_data    (inst_data),
    .o_pc      (inst_pc)
  );

`ifdef UNIDAD_BUSQUEDA_STATS_EN
  logic [ANCHO-1:0] r_espera, r_descartes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_espera    <= '0;
      r_descartes <= '0;
    end else begin
      if (r_estado == FETCH && !mem_ack && r_espera != '1)
        r_espera <= r_espera + ANCHO'(1);
      if (w_descarta_ack && r_descartes != '1)
        r_descartes <= r_descartes + ANCHO'(1);
    end
  end

  assign stat_espera    = r_espera;
  assign stat_descartes = r_descartes;
`endif

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: directed scenarios then a randomized run, with the
// delivered instruction stream checked against a sequential-PC/redirect model.
module tb_unidad_busqueda;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INC      = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_actual;
  logic [31:0] pc_siguiente;
  logic        salto_valido;
  logic [31:0] salto_destino;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef UNIDAD_BUSQUEDA_STATS_EN
  logic [31:0] stat_espera, stat_descartes;
`endif

  unidad_busqueda #(.ANCHO(32), .RESET_PC(RESET_PC), .INCREMENTO(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_actual     (pc_actual),
    .pc_siguiente  (pc_siguiente),
    .salto_valido  (salto_valido),
    .salto_destino (salto_destino),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    ,
    .stat_espera   (stat_espera),
    .stat_descartes(stat_descartes)
`endif
  );

  always #5 clk = ~clk;

  // External PC register: no enable, no reset, loads every edge.
  always @(posedge clk) pc_actual <= pc_siguiente;

  int          checks = 0;
  int          errors = 0;
  int          n_cons = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_pc = '0;
  // memory / decode / redirect environment controls
  bit          rnd = 0;
  int          fixed_wait = 0, wait_cur = 0, wcnt = 0;
  bit          ready_fixed = 1;
  bit          jmp_req = 0;
  logic [31:0] jmp_tgt = '0;
  // previous-cycle snapshot for protocol invariants
  logic        p_valid = 0, p_ready = 0, p_salto = 0, p_req = 0, p_ack = 0, p_rst = 0;
  logic [31:0] p_data = '0, p_pc = '0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h2000_0001 + {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample after the edge, drive inputs for this state, then model.
  task automatic cycle();
    @(posedge clk); #1;
    if (p_rst && rst_n) begin
      if (p_valid && !p_ready && !p_salto) begin
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_data", inst_data, p_data);
        chk("hold_pc", inst_pc, p_pc);
      end
      if (p_req && !p_ack) chk("req_held", {31'd0, mem_req}, 32'd1);
    end
    if (mem_req) begin
      if (wcnt >= wait_cur) begin
        mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr); wcnt = 0;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom; wcnt++;
      end
    end else begin
      mem_ack = 1'b0; wcnt = 0;
      wait_cur = rnd ? int'($urandom_range(0, 3)) : fixed_wait;
    end
    inst_ready = rnd ? 1'($urandom_range(0, 1)) : ready_fixed;
    if (jmp_req || (rnd && $urandom_range(0, 15) == 0)) begin
      salto_valido  = 1'b1;
      salto_destino = jmp_req ? jmp_tgt : ($urandom & 32'hFFFF_FFFC);
    end else begin
      salto_valido = 1'b0;
    end
    jmp_req = 0;
    #1;
    if (rst_n && inst_valid && inst_ready) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", inst_data, mem_fn(exp_pc));
      exp_pc = exp_pc + INC;
      n_cons++;
      last_pc = inst_pc;
    end
    if (rst_n && salto_valido) exp_pc = salto_destino;
    if (!rst_n) exp_pc = RESET_PC;
    p_valid = inst_valid; p_ready = inst_ready; p_salto = salto_valido;
    p_req = mem_req; p_ack = mem_ack; p_rst = rst_n;
    p_data = inst_data; p_pc = inst_pc;
  endtask

  task automatic drain();
    bit ok = 0;
    ready_fixed = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!inst_valid && !mem_req) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_drain", 32'd0, 32'd1);
  endtask

  task automatic until_req();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mem_req) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_req", 32'd0, 32'd1);
  endtask

  task automatic until_valid();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (inst_valid) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_valid", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] d0, a0, s0;
    int          cnt, n0;
    bit          ok;
    rst_n = 1'b0; salto_valido = 0; salto_destino = '0;
    mem_ack = 0; mem_rdata = '0; inst_ready = 0;

    // reset state
    repeat (3) cycle();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_ipc", inst_pc, 32'd0);
    chk("rst_pcsig", pc_siguiente, RESET_PC);
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    chk("rst_espera", stat_espera, 32'd0);
    chk("rst_desc", stat_descartes, 32'd0);
`endif

    // release, zero-wait memory: FETCH then OUT
    rst_n = 1'b1; fixed_wait = 0; ready_fixed = 1;
    cycle();
    chk("b_req", {31'd0, mem_req}, 32'd1);
    chk("b_addr", mem_addr, 32'd0);
    chk("b_pcsig_ack", pc_siguiente, 32'd4);
    cycle();
    chk("b_valid", {31'd0, inst_valid}, 32'd1);
    chk("b_ipc", inst_pc, 32'd0);
    chk("b_idata", inst_data, 32'h2000_0001);
    cycle();
    chk("b_idle", {31'd0, inst_valid | mem_req}, 32'd0);
    cycle();
    chk("b_next_addr", mem_addr, 32'd4);

    // ack delayed by three cycles
    fixed_wait = 3;
    drain();
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    s0 = stat_espera;
`endif
    cnt = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_req) begin
        cnt++;
        if (!mem_ack) chk("c_pc_hold", pc_siguiente, pc_actual);
        else begin ok = 1; break; end
      end
    end
    if (!ok) chk("timeout_c", 32'd0, 32'd1);
    chk("c_req_cycles", 32'(cnt), 32'd4);
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    cycle();
    chk("c_espera", stat_espera - s0, 32'd3);
`endif

    // decode stalls five cycles in OUT
    fixed_wait = 1; ready_fixed = 0;
    until_valid();
    d0 = inst_data; a0 = inst_pc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("d_valid", {31'd0, inst_valid}, 32'd1);
      chk("d_data", inst_data, d0);
      chk("d_pc", inst_pc, a0);
      chk("d_noreq", {31'd0, mem_req}, 32'd0);
      chk("d_pc_held", pc_siguiente, pc_actual);
    end

    // redirect during a waiting FETCH
    fixed_wait = 3;
    drain();
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    s0 = stat_descartes;
`endif
    until_req();
    jmp_req = 1; jmp_tgt = 32'h0000_0100;
    cycle();
    chk("e_pcsig", pc_siguiente, 32'h100);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("e_no_valid", {31'd0, inst_valid}, 32'd0);
      if (!mem_req) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_e", 32'd0, 32'd1);
    until_req();
    chk("e_addr", mem_addr, 32'h100);
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    chk("e_desc", stat_descartes - s0, 32'd1);
`endif

    // redirect together with inst_ready in OUT
    fixed_wait = 0; ready_fixed = 0;
    until_valid();
    n0 = n_cons;
    ready_fixed = 1; jmp_req = 1; jmp_tgt = 32'h0000_0200;
    cycle();
    chk("f_consumed", 32'(n_cons - n0), 32'd1);
    cycle();
    chk("f_valid_clr", {31'd0, inst_valid}, 32'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_cons == n0 + 2) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_f", 32'd0, 32'd1);
    chk("f_target_pc", last_pc, 32'h200);

    // PC wrap at the top of the address space
    jmp_req = 1; jmp_tgt = 32'hFFFF_FFFC;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mem_req && mem_ack && mem_addr == 32'hFFFF_FFFC) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_g", 32'd0, 32'd1);
    chk("g_wrap", pc_siguiente, 32'd0);
    drain();

    // reset in the middle of a waiting fetch
    fixed_wait = 3;
    until_req();
    rst_n = 1'b0;
    #1;
    chk("i_req", {31'd0, mem_req}, 32'd0);
    chk("i_valid", {31'd0, inst_valid}, 32'd0);
    chk("i_addr", mem_addr, 32'd0);
    chk("i_pcsig", pc_siguiente, RESET_PC);
`ifdef UNIDAD_BUSQUEDA_STATS_EN
    chk("i_espera", stat_espera, 32'd0);
`endif
    repeat (2) cycle();
    rst_n = 1'b1;

    // randomized traffic against the stream model
    n0 = n_cons;
    rnd = 1;
    repeat (800) cycle();
    rnd = 0;
    chk("h_progress", {31'd0, (n_cons - n0) > 20}, 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
